mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory controller between the CPU core and a single byte-wide, single-port external RAM.
//  Serves two requesters:
//   - instruction fetch: 32-bit reads on the core's rom_* interface;
//   - MEM stage: byte, half or word loads and stores.
//  Serialises each access into byte transactions and raises per-requester stall requests for ctrl.
// PARAMETERS
//  ADDR_W  17  external RAM byte-address width; addresses wrap modulo 2^ADDR_W
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous, active-low reset
//  if_req_i        in   1       fetch request (level, held until if_done_o)
//  if_addr_i       in   32      fetch byte address
//  if_flush_i      in   1       branch flush: abort an in-flight fetch
//  if_data_o       out  32      fetched instruction, little-endian
//  if_done_o       out  1       1-cycle pulse: if_data_o valid
//  mem_req_i       in   1       MEM-stage request (mem_ce; level, held until mem_done_o)
//  mem_we_i        in   1       1 = store, 0 = load
//  mem_sel_i       in   4       size: 0001 = byte, 0011 = half, 1111 = word; any other value = word
//  mem_addr_i      in   32      byte address; unaligned accesses allowed
//  mem_wdata_i     in   32      store data, low bytes first
//  mem_rdata_o     out  32      load data, zero-extended (MEM stage sign-extends)
//  mem_done_o      out  1       1-cycle pulse: access complete
//  stallreq_if_o   out  1       if_req_i & ~if_done_o (combinational)
//  stallreq_mem_o  out  1       mem_req_i & ~mem_done_o (combinational)
//  ram_addr_o      out  ADDR_W  RAM byte address (registered)
//  ram_wr_o        out  1       RAM write strobe (registered)
//  ram_dout_o      out  8       RAM write byte (registered)
//  ram_din_i       in   8       RAM read byte; valid the cycle after ram_addr_o is presented
// BEHAVIOUR
//  Reset (rst = 0, async)
//   - All registered outputs go to 0 and the FSM goes to IDLE; ram_wr_o drops immediately.
//   - A store interrupted by reset is left partially written; there is no rollback.
//  FSM states
//   - IDLE: arbitrate.
//   - RD:   issue and capture read bytes.
//   - WR:   issue write bytes.
//   - DONE: one cycle; the done pulse is high here.
//  Transitions
//   - IDLE -> RD or WR on a sampled request. IDLE -> IDLE otherwise.
//   - RD or WR -> DONE after the last byte.
//   - RD (fetch only) -> IDLE on if_flush_i.
//   - DONE -> IDLE.
//  Arbitration in IDLE
//   - MEM wins over IF when both are requesting; MEM is the older instruction.
//   - The winner's address, size, we and wdata are latched at the accept edge.
//  Byte count N = 1, 2 or 4 from the size; fetch N = 4. Byte k uses address (A+k) mod 2^ADDR_W.
//  Read timing
//   - Accept edge E0 drives ram_addr_o = A.
//   - Edge Ek drives A+k, for k < N.
//   - Byte k is captured at edge E(k+2) into bits [8k+7:8k].
//   - The done pulse and data are valid in the cycle after E(N+1): N+1 cycles of latency.
//  Write timing
//   - Edge Ek drives ram_wr_o = 1, ram_addr_o = A+k and ram_dout_o = wdata[8k+7:8k].
//   - ram_wr_o is 0 from edge EN; mem_done_o is high after EN: N cycles of latency.
//  Done cycle
//   - Requests are ignored in DONE. The requester drops or changes req in the done cycle.
//   - Re-arbitration happens the cycle after DONE, so there are no duplicate accesses.
//   - Data outputs hold their value until the next done pulse.
//  Flush
//   - if_flush_i in RD-for-IF returns to IDLE at the next edge with no if_done_o.
//   - if_flush_i in IDLE blocks IF acceptance that cycle.
//   - if_flush_i is ignored during MEM accesses; a store is never aborted.
//  Other rules
//   - ram_wr_o is never high outside WR.
//   - if_done_o and mem_done_o are never high together.
// STRUCTURE
//  defines.v additions:
//   - `RamAddrBus, `ByteBus;
//   - state encodings MC_IDLE, MC_RD, MC_WR, MC_DONE;
//   - size codes for mem_sel_i.
//  Single module, one FSM plus a 2-bit byte counter; no sub-module.
// TESTING
//  1. Fetch A=0x100, RAM holds 13 05 00 00
//     -> if_data_o = 0x00000513 with if_done_o 5 cycles after accept; stallreq_if_o high until then.
//  2. Store sb A=0x1FFFF, data 0xAB, ADDR_W=17
//     -> one ram_wr_o cycle at addr 0x1FFFF, dout 0xAB; mem_done_o 1 cycle later.
//  3. Store sw A=0x1FFFE, data 0x11223344
//     -> writes 44,33,22,11 to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 (wrap).
//  4. if_req_i and mem_req_i (lh, A=0x3, RAM 80 FF) rise together
//     -> MEM served first: mem_rdata_o = 0x0000FF80 at 3 cycles; the fetch starts after DONE.
//  5. Fetch accepted, if_flush_i pulsed at the second edge
//     -> no if_done_o, back to IDLE; a new fetch from the branch target completes normally.
//  6. rst low during the third byte of sw
//     -> ram_wr_o = 0 immediately, FSM in IDLE, first two bytes stay written, all done outputs 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serialising memory controller:
// FSM state encodings, mem_sel_i size codes and the size-to-byte-count helper.
package mem_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 17;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_RD   = 2'd1;
  localparam logic [1:0] MC_WR   = 2'd2;
  localparam logic [1:0] MC_DONE = 2'd3;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Any size code other than byte or half is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [3:0] sel);
    case (sel)
      SEL_BYTE: return 3'd1;
      SEL_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side bus of the memory controller: fetch port, MEM-stage port and stall requests.
// master = CPU core side, slave = memory controller side.
interface mem_ctrl_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_data_o;
  logic        if_done_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;

  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    input  stallreq_if_o, stallreq_mem_o
  );

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    output stallreq_if_o, stallreq_mem_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller between the CPU core and a byte-wide single-port synchronous RAM.
// Instruction fetches (always 32 bits) and MEM-stage loads/stores (1, 2 or 4 bytes,
// unaligned allowed) are serialised into byte transactions; MEM wins arbitration.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         core,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  logic [1:0]        state;
  logic              owner_mem;
  logic [ADDR_W-1:0] base_addr;
  logic [2:0]        nbytes;
  logic [31:0]       wdata;
  // Counts edges since the accept edge; reads need N+1 of them because each
  // byte arrives one cycle after its address, so this runs up to 5.
  logic [2:0]        step;
  logic [31:0]       rbuf;
  logic [31:0]       rbuf_next;
  logic [1:0]        cap_idx;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic              unused_addr_hi;

  // Upper address bits beyond the RAM width are deliberately ignored (address wraps).
  assign unused_addr_hi = ^{core.if_addr_i[31:ADDR_W], core.mem_addr_i[31:ADDR_W]};

  // The byte arriving at step k was addressed at step k-2.
  assign cap_idx = step[1:0] - 2'd2;

  // Read assembly buffer with the byte arriving this cycle merged in.
  always_comb begin
    rbuf_next = rbuf;
    if (step >= 3'd2) begin
      rbuf_next[{cap_idx, 3'b000} +: 8] = ram_din_i;
    end
  end

  // Main FSM: arbitration, byte issue/capture, done handling and registered RAM outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= MC_IDLE;
      owner_mem   <= 1'b0;
      base_addr   <= '0;
      nbytes      <= 3'd0;
      wdata       <= 32'd0;
      step        <= 3'd0;
      rbuf        <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
    end else begin
      case (state)
        MC_IDLE: begin
          ram_wr_o <= 1'b0;
          if (core.mem_req_i) begin
            owner_mem  <= 1'b1;
            base_addr  <= core.mem_addr_i[ADDR_W-1:0];
            nbytes     <= byte_count(core.mem_sel_i);
            wdata      <= core.mem_wdata_i;
            step       <= 3'd1;
            rbuf       <= 32'd0;
            ram_addr_o <= core.mem_addr_i[ADDR_W-1:0];
            if (core.mem_we_i) begin
              state      <= MC_WR;
              ram_wr_o   <= 1'b1;
              ram_dout_o <= core.mem_wdata_i[7:0];
            end else begin
              state <= MC_RD;
            end
          end else if (core.if_req_i && !core.if_flush_i) begin
            owner_mem  <= 1'b0;
            base_addr  <= core.if_addr_i[ADDR_W-1:0];
            nbytes     <= 3'd4;
            step       <= 3'd1;
            rbuf       <= 32'd0;
            ram_addr_o <= core.if_addr_i[ADDR_W-1:0];
            state      <= MC_RD;
          end
        end
        MC_RD: begin
          if (!owner_mem && core.if_flush_i) begin
            state <= MC_IDLE;
          end else begin
            if (step < nbytes) begin
              ram_addr_o <= base_addr + ADDR_W'(step);
            end
            rbuf <= rbuf_next;
            step <= step + 3'd1;
            if (step == nbytes + 3'd1) begin
              state <= MC_DONE;
              if (owner_mem) begin
                mem_rdata_q <= rbuf_next;
              end else begin
                if_data_q <= rbuf_next;
              end
            end
          end
        end
        MC_WR: begin
          step <= step + 3'd1;
          if (step < nbytes) begin
            ram_wr_o   <= 1'b1;
            ram_addr_o <= base_addr + ADDR_W'(step);
            ram_dout_o <= wdata[{step[1:0], 3'b000} +: 8];
          end else begin
            ram_wr_o <= 1'b0;
            state    <= MC_DONE;
          end
        end
        default: begin
          ram_wr_o <= 1'b0;
          state    <= MC_IDLE;
        end
      endcase
    end
  end

  assign core.if_done_o      = (state == MC_DONE) && !owner_mem;
  assign core.mem_done_o     = (state == MC_DONE) && owner_mem;
  assign core.if_data_o      = if_data_q;
  assign core.mem_rdata_o    = mem_rdata_q;
  assign core.stallreq_if_o  = core.if_req_i && !core.if_done_o;
  assign core.stallreq_mem_o = core.mem_req_i && !core.mem_done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, golden memory with
// expected-write and expected-completion queues, directed access sequences.
module tb_mem_ctrl;

  localparam int ADDR_W = 17;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_exp_t;

  typedef struct packed {
    bit          is_mem;
    bit          is_load;
    logic [31:0] data;
  } done_exp_t;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;

  logic [7:0] ram  [0:(1<<ADDR_W)-1];
  logic [7:0] gold [0:(1<<ADDR_W)-1];

  wr_exp_t   wq[$];
  done_exp_t cq[$];
  wr_exp_t   w_cur;
  done_exp_t d_cur;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl_if bus ();

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (bus),
    .ram_addr_o(ram_addr),
    .ram_wr_o  (ram_wr),
    .ram_dout_o(ram_dout),
    .ram_din_i (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: write strobe or bench preload, registered read.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    else if (pre_we) ram[pre_addr] <= pre_data;
    ram_din <= ram[ram_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  function automatic int model_nbytes(input logic [3:0] sel);
    if (sel == 4'b0001) return 1;
    if (sel == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0]       d;
    logic [ADDR_W-1:0] a;
    d = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr[ADDR_W-1:0] + ADDR_W'(k);
      d[8*k +: 8] = gold[a];
    end
    return d;
  endfunction

  task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = addr[ADDR_W-1:0] + ADDR_W'(k);
      gold[a] = wd[8*k +: 8];
      wq.push_back({a, wd[8*k +: 8]});
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    gold[a]  = d;
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Waits for the requester's done pulse, checking its stall request each cycle.
  task automatic wait_done(input bit is_mem, output int c);
    bit seen;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 60) begin
      @(posedge clk); #1;
      c++;
      if (is_mem ? bus.mem_done_o : bus.if_done_o) seen = 1'b1;
      else check_output("stall_busy", {31'd0, is_mem ? bus.stallreq_mem_o : bus.stallreq_if_o}, 32'd1);
    end
    if (!seen) begin
      fail_now("done_timeout");
      c = -1;
    end else begin
      check_output("stall_at_done", {31'd0, is_mem ? bus.stallreq_mem_o : bus.stallreq_if_o}, 32'd0);
    end
  endtask

  // One access from idle: model update, request, latency check, release.
  task automatic apply_stimulus(input bit is_mem, input bit we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input int exp_lat, input string name);
    int n;
    int c;
    n = is_mem ? model_nbytes(sel) : 4;
    if (is_mem && we) begin
      model_store(addr, n, wd);
      cq.push_back({1'b1, 1'b0, 32'd0});
    end else begin
      cq.push_back({is_mem, 1'b1, model_read(addr, n)});
    end
    if (is_mem) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_sel_i   = sel;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wd;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    wait_done(is_mem, c);
    if (c > 0) check_output(name, c - 1, exp_lat);
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  // Compare process: done exclusivity, RAM write stream and completion data.
  always @(negedge clk) begin
    check_output("done_exclusive", {31'd0, bus.if_done_o & bus.mem_done_o}, 32'd0);
    if (ram_wr) begin
      if (wq.size() == 0) fail_now("unexpected_write");
      else begin
        w_cur = wq.pop_front();
        check_output("wr_addr", {15'd0, ram_addr}, {15'd0, w_cur.addr});
        check_output("wr_byte", {24'd0, ram_dout}, {24'd0, w_cur.data});
      end
    end
    if (bus.if_done_o || bus.mem_done_o) begin
      if (cq.size() == 0) fail_now("unexpected_done");
      else begin
        d_cur = cq.pop_front();
        check_output("done_owner", {31'd0, bus.mem_done_o}, {31'd0, d_cur.is_mem});
        if (d_cur.is_load)
          check_output("done_data", d_cur.is_mem ? bus.mem_rdata_o : bus.if_data_o, d_cur.data);
      end
    end
  end

  initial begin
    int c;
    int mem_c;
    int if_c;
    rst = 1'b0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = 8'd0;
    bus.if_req_i = 1'b0;
    bus.if_addr_i = 32'd0;
    bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_sel_i = 4'd0;
    bus.mem_addr_i = 32'd0;
    bus.mem_wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    preload(17'h00100, 8'h13); preload(17'h00101, 8'h05);
    preload(17'h00102, 8'h00); preload(17'h00103, 8'h00);
    preload(17'h00003, 8'h80); preload(17'h00004, 8'hFF);
    preload(17'h00200, 8'h77); preload(17'h00201, 8'h66);
    preload(17'h00202, 8'h55); preload(17'h00203, 8'h44);
    for (int i = 0; i < 4; i++) preload(17'h00040 + 17'(i), 8'h00);

    check_output("rst_ram_addr", {15'd0, ram_addr}, 32'd0);
    check_output("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check_output("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check_output("rst_if_data", bus.if_data_o, 32'd0);
    check_output("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    check_output("rst_dones", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(1'b0, 1'b0, 4'b1111, 32'h100, 32'd0, 5, "t1_fetch_latency");
    check_output("t1_fetch_literal", bus.if_data_o, 32'h00000513);

    apply_stimulus(1'b1, 1'b1, 4'b0001, 32'h1FFFF, 32'h000000AB, 1, "t2_sb_latency");
    check_output("t2_ram_1ffff", {24'd0, ram[17'h1FFFF]}, 32'h000000AB);

    apply_stimulus(1'b1, 1'b1, 4'b1111, 32'h1FFFE, 32'h11223344, 4, "t3_sw_latency");
    check_output("t3_ram_1fffe", {24'd0, ram[17'h1FFFE]}, 32'h00000044);
    check_output("t3_ram_00000", {24'd0, ram[17'h00000]}, 32'h00000022);
    check_output("t3_ram_00001", {24'd0, ram[17'h00001]}, 32'h00000011);

    apply_stimulus(1'b1, 1'b0, 4'b0101, 32'h1FFFE, 32'd0, 5, "t3_lw_odd_sel_latency");
    check_output("t3_lw_literal", bus.mem_rdata_o, 32'h11223344);

    // Both requesters at once: MEM first, fetch accepted after DONE.
    cq.push_back({1'b1, 1'b1, model_read(32'h3, 2)});
    cq.push_back({1'b0, 1'b1, model_read(32'h100, 4)});
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_sel_i = 4'b0011; bus.mem_addr_i = 32'h3;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    c = 0; mem_c = -1; if_c = -1;
    while (if_c < 0 && c < 60) begin
      @(posedge clk); #1;
      c++;
      if (bus.mem_done_o) begin mem_c = c; bus.mem_req_i = 1'b0; end
      if (bus.if_done_o) begin if_c = c; bus.if_req_i = 1'b0; end
    end
    check_output("t4_mem_latency", mem_c - 1, 32'd3);
    check_output("t4_if_latency", if_c - 1, 32'd10);
    check_output("t4_lh_literal", bus.mem_rdata_o, 32'h0000FF80);
    check_output("t4_fetch_literal", bus.if_data_o, 32'h00000513);
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
    @(posedge clk); #1;

    // Flush an in-flight fetch, hold flush one idle cycle, then fetch the target.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200; bus.if_flush_i = 1'b0;
    @(posedge clk); #1;
    bus.if_flush_i = 1'b1;
    @(posedge clk); #1;
    check_output("t5_no_done_flush", {31'd0, bus.if_done_o}, 32'd0);
    bus.if_addr_i = 32'h100;
    @(posedge clk); #1;
    check_output("t5_no_done_idle", {31'd0, bus.if_done_o}, 32'd0);
    bus.if_flush_i = 1'b0;
    cq.push_back({1'b0, 1'b1, model_read(32'h100, 4)});
    wait_done(1'b0, c);
    if (c > 0) check_output("t5_target_latency", c - 1, 32'd5);
    bus.if_req_i = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(1'b1, 1'b1, 4'b0011, 32'h201, 32'h0000BEEF, 2, "sh_latency");
    apply_stimulus(1'b1, 1'b0, 4'b0011, 32'h201, 32'd0, 3, "lh_latency");
    check_output("lh_literal", bus.mem_rdata_o, 32'h0000BEEF);
    apply_stimulus(1'b1, 1'b0, 4'b0001, 32'h4, 32'd0, 2, "lb_latency");
    check_output("lb_literal", bus.mem_rdata_o, 32'h000000FF);

    // Reset in the middle of the third byte of a word store.
    model_store(32'h40, 2, 32'hDDCCBBAA);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_sel_i = 4'b1111;
    bus.mem_addr_i = 32'h40; bus.mem_wdata_i = 32'hDDCCBBAA;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check_output("t6_wr_dropped", {31'd0, ram_wr}, 32'd0);
    check_output("t6_dones_low", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    check_output("t6_addr_cleared", {15'd0, ram_addr}, 32'd0);
    check_output("t6_rdata_cleared", bus.mem_rdata_o, 32'd0);
    bus.mem_req_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    check_output("t6_ram_40", {24'd0, ram[17'h40]}, 32'h000000AA);
    check_output("t6_ram_41", {24'd0, ram[17'h41]}, 32'h000000BB);
    check_output("t6_ram_42", {24'd0, ram[17'h42]}, 32'h00000000);
    check_output("t6_ram_43", {24'd0, ram[17'h43]}, 32'h00000000);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b0, 4'b1111, 32'h100, 32'd0, 5, "t6_fetch_after_reset");

    check_output("writes_drained", wq.size(), 32'd0);
    check_output("dones_drained", cq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
